// File: rtl/seg7_counter_pkg.sv
// Shared constants for the multi-digit BCD counter with multiplexed 7-segment display.
package seg7_counter_pkg;
   localparam int                    PRESCALE_W        = 24;
   localparam logic [PRESCALE_W-1:0] DEFAULT_MAX_COUNT = 24'd10_000_000;
   localparam logic [3:0]            BCD_MAX           = 4'd9;
   localparam int                    SCAN_W            = 2;
   localparam int                    SEG_W             = 7;
endpackage

// File: rtl/seg7_multi_counter_decoder.sv
// BCD digit to 7-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
module seg7_multi_counter_decoder
   import seg7_counter_pkg::*;
(
   input  logic [3:0]       digit,
   output logic [SEG_W-1:0] segments
);

   always_comb begin
      segments = '0;
      case (digit)
         4'd0:    segments = 7'h3F;
         4'd1:    segments = 7'h06;
         4'd2:    segments = 7'h5B;
         4'd3:    segments = 7'h4F;
         4'd4:    segments = 7'h66;
         4'd5:    segments = 7'h6D;
         4'd6:    segments = 7'h7D;
         4'd7:    segments = 7'h07;
         4'd8:    segments = 7'h7F;
         4'd9:    segments = 7'h6F;
         default: segments = '0;
      endcase
   end

endmodule

// File: rtl/seg7_multi_counter.sv
// Prescaled up/down BCD counter of NUM_DIGITS digits with a time-multiplexed
// 7-segment display scan.
module seg7_multi_counter
   import seg7_counter_pkg::*;
#(
   parameter int                    NUM_DIGITS = 4,
   parameter logic [PRESCALE_W-1:0] MAX_COUNT  = DEFAULT_MAX_COUNT,
   parameter logic [15:0]           MUX_COUNT  = 16'd10_000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic                    up,
   input  logic                    pause,
   input  logic                    clear,
   input  logic [7:0]              compare_in,
   output logic [SEG_W-1:0]        segments,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    tick,
   output logic                    rollover
);

   localparam logic [15:0] MUX_LAST = MUX_COUNT - 16'd1;

   logic [PRESCALE_W-1:0]      compare;
   logic [PRESCALE_W-1:0]      prescaler;
   logic [NUM_DIGITS-1:0][3:0] digits;
   logic [NUM_DIGITS-1:0][3:0] digits_nxt;
   logic                       step;
   logic                       carry;
   logic                       wrap;
   logic [15:0]                scan_cnt;
   logic [SCAN_W-1:0]          scan_idx;
   logic [3:0]                 scan_digit;
   logic [NUM_DIGITS-1:0]      scan_onehot;
   logic [SEG_W-1:0]           seg_dec;

   always_comb begin
      compare = MAX_COUNT;
      if (compare_in != 8'd0)
         compare = {6'b0, compare_in, 10'b0};
   end

   // >= rather than == so a lowered compare steps at once instead of wrapping
   assign step = ena && !pause && !clear && (prescaler >= compare);

   // Carry (up) or borrow (down) ripples from digit 0; carry out of the top
   // digit marks the full-range wrap.
   always_comb begin
      digits_nxt = digits;
      carry      = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (up) begin
               if (digits[i] == BCD_MAX) begin
                  digits_nxt[i] = 4'd0;
               end else begin
                  digits_nxt[i] = digits[i] + 4'd1;
                  carry         = 1'b0;
               end
            end else begin
               if (digits[i] == 4'd0) begin
                  digits_nxt[i] = BCD_MAX;
               end else begin
                  digits_nxt[i] = digits[i] - 4'd1;
                  carry         = 1'b0;
               end
            end
         end
      end
      wrap = carry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         digits    <= '0;
         tick      <= 1'b0;
         rollover  <= 1'b0;
      end else begin
         tick     <= step;
         rollover <= step && wrap;
         if (clear) begin
            prescaler <= '0;
            digits    <= '0;
         end else if (step) begin
            prescaler <= '0;
            digits    <= digits_nxt;
         end else if (ena && !pause) begin
            prescaler <= prescaler + PRESCALE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (ena) begin
         if (scan_cnt >= MUX_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == SCAN_W'(NUM_DIGITS - 1)) ? '0 : SCAN_W'(scan_idx + 1);
         end else begin
            scan_cnt <= scan_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      scan_digit  = '0;
      scan_onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx == SCAN_W'(i)) begin
            scan_digit     = digits[i];
            scan_onehot[i] = 1'b1;
         end
      end
   end

   seg7_multi_counter_decoder u_decoder (
      .digit    (scan_digit),
      .segments (seg_dec)
   );

   // Display registers blank one cycle after ena drops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segments <= '0;
         digit_en <= '0;
      end else if (ena) begin
         segments <= seg_dec;
         digit_en <= scan_onehot;
      end else begin
         segments <= '0;
         digit_en <= '0;
      end
   end

   assign bcd = digits;

endmodule

// File: tb/tb_seg7_multi_counter.sv
// Bench for seg7_multi_counter: a 2-digit and a 4-digit instance share stimulus
// and are compared each cycle against an arithmetic model of the counter.
module tb_seg7_multi_counter;

   localparam int MAXC = 20;
   localparam int MUXC = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena, up, pause, clear;
   logic [7:0] compare_in;

   logic [6:0]  seg_a, seg_b;
   logic [1:0]  en_a;
   logic [3:0]  en_b;
   logic [7:0]  bcd_a;
   logic [15:0] bcd_b;
   logic        tick_a, tick_b, roll_a, roll_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seg7_multi_counter #(.NUM_DIGITS(2), .MAX_COUNT(24'd20), .MUX_COUNT(16'd4)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .up(up), .pause(pause), .clear(clear),
      .compare_in(compare_in), .segments(seg_a), .digit_en(en_a), .bcd(bcd_a),
      .tick(tick_a), .rollover(roll_a));

   seg7_multi_counter #(.NUM_DIGITS(4), .MAX_COUNT(24'd20), .MUX_COUNT(16'd4)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .up(up), .pause(pause), .clear(clear),
      .compare_in(compare_in), .segments(seg_b), .digit_en(en_b), .bcd(bcd_b),
      .tick(tick_b), .rollover(roll_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int digit_of(input int v, input int i);
      int p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      return (v / p) % 10;
   endfunction

   function automatic logic [15:0] to_bcd(input int v, input int n);
      logic [15:0] r = '0;
      for (int i = 0; i < n; i++) r[4*i +: 4] = 4'(digit_of(v, i));
      return r;
   endfunction

   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // Reference model: counts as plain integers, display as value/10^i digit
   int         m_pre, m_cnt_a, m_cnt_b, m_scnt, m_idx_a, m_idx_b, m_cmp;
   int         m_en_a, m_en_b;
   logic       m_stp, m_tick, m_roll_a, m_roll_b;
   logic [6:0] m_seg_a, m_seg_b;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_pre = 0; m_cnt_a = 0; m_cnt_b = 0; m_scnt = 0; m_idx_a = 0; m_idx_b = 0;
         m_en_a = 0; m_en_b = 0; m_tick = 0; m_roll_a = 0; m_roll_b = 0;
         m_seg_a = 0; m_seg_b = 0;
      end else begin
         m_cmp = (compare_in == 8'd0) ? MAXC : int'(compare_in) * 1024;
         m_stp = ena && !pause && !clear && (m_pre >= m_cmp);
         m_seg_a = ena ? seg_tab[digit_of(m_cnt_a, m_idx_a)] : 7'd0;
         m_seg_b = ena ? seg_tab[digit_of(m_cnt_b, m_idx_b)] : 7'd0;
         m_en_a = ena ? (1 << m_idx_a) : 0;
         m_en_b = ena ? (1 << m_idx_b) : 0;
         m_tick = m_stp;
         m_roll_a = m_stp && (up ? (m_cnt_a == 99) : (m_cnt_a == 0));
         m_roll_b = m_stp && (up ? (m_cnt_b == 9999) : (m_cnt_b == 0));
         if (clear) begin
            m_cnt_a = 0; m_cnt_b = 0; m_pre = 0;
         end else if (m_stp) begin
            m_cnt_a = (m_cnt_a + (up ? 1 : 99)) % 100;
            m_cnt_b = (m_cnt_b + (up ? 1 : 9999)) % 10000;
            m_pre = 0;
         end else if (ena && !pause) begin
            m_pre++;
         end
         if (ena) begin
            m_scnt++;
            if (m_scnt == MUXC) begin
               m_scnt = 0;
               m_idx_a = (m_idx_a + 1) % 2;
               m_idx_b = (m_idx_b + 1) % 4;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      check("m_bcd_a", bcd_a, to_bcd(m_cnt_a, 2));
      check("m_bcd_b", bcd_b, to_bcd(m_cnt_b, 4));
      check("m_seg_a", seg_a, m_seg_a);
      check("m_seg_b", seg_b, m_seg_b);
      check("m_en_a", en_a, m_en_a);
      check("m_en_b", en_b, m_en_b);
      check("m_tick_a", tick_a, m_tick);
      check("m_tick_b", tick_b, m_tick);
      check("m_roll_a", roll_a, m_roll_a);
      check("m_roll_b", roll_b, m_roll_b);
   end

   task automatic wait_tick(input int limit, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!tick_a && cycles < limit);
   endtask

   typedef struct {
      logic        dir_up;
      int          steps;
      logic [7:0]  exp_bcd_a;
      logic        exp_roll_a;
      logic [15:0] exp_bcd_b;
      logic        exp_roll_b;
   } vec_t;

   vec_t vecs [8];
   logic [3:0] mux_seq [5];

   initial begin
      int c;
      vecs[0] = '{1'b1,   1, 8'h01, 1'b0, 16'h0001, 1'b0};
      vecs[1] = '{1'b1,  10, 8'h10, 1'b0, 16'h0010, 1'b0};
      vecs[2] = '{1'b1,  37, 8'h37, 1'b0, 16'h0037, 1'b0};
      vecs[3] = '{1'b0,   1, 8'h99, 1'b1, 16'h9999, 1'b1};
      vecs[4] = '{1'b0,   2, 8'h98, 1'b0, 16'h9998, 1'b0};
      vecs[5] = '{1'b1, 100, 8'h00, 1'b1, 16'h0100, 1'b0};
      vecs[6] = '{1'b0,  11, 8'h89, 1'b0, 16'h9989, 1'b0};
      vecs[7] = '{1'b1,  99, 8'h99, 1'b0, 16'h0099, 1'b0};
      mux_seq[0] = 4'b0001; mux_seq[1] = 4'b0010; mux_seq[2] = 4'b0100;
      mux_seq[3] = 4'b1000; mux_seq[4] = 4'b0001;

      ena = 1'b1; up = 1'b1; pause = 1'b0; clear = 1'b0; compare_in = 8'd0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_seg", seg_a, 7'd0);
      check("rst_en", en_b, 4'd0);
      check("rst_bcd", bcd_b, 16'd0);
      check("rst_tick", tick_a, 1'b0);
      check("rst_roll", roll_b, 1'b0);

      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_en", en_a, 2'b01);
      check("post_rst_seg", seg_a, 7'h3F);
      check("post_rst_seg_b", seg_b, 7'h3F);
      for (int k = 0; k < 5; k++) begin
         check("mux_seq", en_b, mux_seq[k]);
         repeat (4) @(negedge clk);
      end

      ena = 1'b0;
      @(negedge clk);
      check("ena_off_seg", seg_b, 7'd0);
      check("ena_off_en", en_b, 4'd0);
      check("ena_off_en_a", en_a, 2'd0);
      ena = 1'b1;

      // compare_in=1: one step every 1025 cycles
      compare_in = 8'd1;
      wait_tick(3000, c);
      check("sync_timeout", (c < 3000), 1'b1);
      wait_tick(3000, c);
      check("interval_1025", c, 1025);
      wait_tick(3000, c);
      check("interval_1025b", c, 1025);

      // pause 5000 cycles mid-interval; remaining count resumes
      repeat (500) @(negedge clk);
      pause = 1'b1;
      repeat (5000) @(negedge clk);
      pause = 1'b0;
      wait_tick(3000, c);
      check("pause_resume", c, 525);

      // clear lands on the edge where the prescaler has reached compare
      repeat (1024) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_bcd", bcd_b, 16'd0);
      check("clr_tick", tick_a, 1'b0);
      check("clr_roll", roll_a, 1'b0);
      wait_tick(3000, c);
      check("clr_next_tick", c, 1025);

      // lower compare below the running prescaler
      compare_in = 8'd2;
      repeat (2000) @(negedge clk);
      compare_in = 8'd1;
      wait_tick(3000, c);
      check("lower_cmp_step", c, 1);
      wait_tick(3000, c);
      check("lower_cmp_int", c, 1025);

      // table vectors from a cleared count, compare_in=0 (21-cycle steps)
      compare_in = 8'd0;
      for (int v = 0; v < 8; v++) begin
         clear = 1'b1;
         up = vecs[v].dir_up;
         @(negedge clk);
         clear = 1'b0;
         for (int s = 0; s < vecs[v].steps; s++) begin
            wait_tick(100, c);
            check("tbl_interval", c, 21);
         end
         check("tbl_bcd_a", bcd_a, vecs[v].exp_bcd_a);
         check("tbl_roll_a", roll_a, vecs[v].exp_roll_a);
         check("tbl_bcd_b", bcd_b, vecs[v].exp_bcd_b);
         check("tbl_roll_b", roll_b, vecs[v].exp_roll_b);
      end

      // randomized control traffic
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         ena = ($urandom % 8) != 0;
         pause = ($urandom % 8) == 0;
         clear = ($urandom % 64) == 0;
         if (($urandom % 32) == 0) up = ~up;
         compare_in = (($urandom % 64) == 0) ? 8'($urandom) : 8'd0;
      end

      // asynchronous reset mid-count
      @(negedge clk);
      ena = 1'b1; pause = 1'b0; clear = 1'b0; up = 1'b1; compare_in = 8'd0;
      wait_tick(100, c);
      check("pre_async_tick", c < 100, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_seg_a", seg_a, 7'd0);
      check("async_en_a", en_a, 2'd0);
      check("async_bcd_a", bcd_a, 8'd0);
      check("async_tick", tick_a, 1'b0);
      check("async_roll", roll_a, 1'b0);
      check("async_seg_b", seg_b, 7'd0);
      check("async_en_b", en_b, 4'd0);
      check("async_bcd_b", bcd_b, 16'd0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
